// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU constants and command/response types for the ALU
//            datapath, its issuer and benches.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_TAG_W = 4;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    typedef struct packed {
        logic                 opsel;
        logic [ALU_WIDTH-1:0] in0;
        logic [ALU_WIDTH-1:0] in1;
    } alu_cmd_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        logic [ALU_TAG_W-1:0] tag;
    } alu_rsp_t;

endpackage

`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
// ============================================================================
// Module   : alu_rsp_fifo
// Brief    : DEPTH-entry result FIFO; head is read straight from the storage
//            registers and forced to zero while empty.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rsp_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_rsp_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    T                   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Storage is not reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_cnt_full);
    assign o_count = r_count;
    assign o_head  = o_empty ? T'('0) : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/alu_issuer.sv
// ============================================================================
// Module   : alu_issuer
// Brief    : Credit-based initiator for the fixed-latency ALU; issues ops,
//            tracks them for LATENCY cycles and returns tagged results.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = ALU_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_opsel,
    input  logic [WIDTH-1:0] cmd_in0,
    input  logic [WIDTH-1:0] cmd_in1,
    output logic             alu_opsel,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag
);

    localparam int c_cred_w = $clog2(DEPTH + 1);

    localparam logic [c_cred_w-1:0] c_cred_max = c_cred_w'(DEPTH);
    localparam logic [c_cred_w-1:0] c_cred_one = c_cred_w'(1);
    localparam logic [TAG_W-1:0]    c_tag_one  = TAG_W'(1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic [c_cred_w-1:0] r_credits;
    logic [TAG_W-1:0]    r_tag_cnt;
    logic                r_opsel;
    logic [WIDTH-1:0]    r_in0;
    logic [WIDTH-1:0]    r_in1;
    logic [LATENCY:0]    r_vld;
    logic [TAG_W-1:0]    r_tag [LATENCY+1];

    logic                w_accept;
    logic                w_pop;
    logic                w_push;
    rsp_t                w_push_data;
    rsp_t                w_head;
    logic                w_full;
    logic                w_empty;
    logic [c_cred_w-1:0] w_count;

    assign cmd_ready   = (r_credits != '0) && !reset;
    assign w_accept    = cmd_valid && cmd_ready;
    assign rsp_valid   = !w_empty && !reset;
    assign w_pop       = rsp_valid && rsp_ready;
    assign w_push      = r_vld[LATENCY];
    assign w_push_data = '{data: alu_out, tag: r_tag[LATENCY]};

    // Operands are presented for exactly one cycle, then fall back to zero.
    always_ff @(posedge clk) begin
        if (reset || !w_accept) begin
            r_opsel <= OP_MUL;
            r_in0   <= '0;
            r_in1   <= '0;
        end else begin
            r_opsel <= cmd_opsel;
            r_in0   <= cmd_in0;
            r_in1   <= cmd_in1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_cnt <= '0;
            r_credits <= c_cred_max;
        end else begin
            if (w_accept) begin
                r_tag_cnt <= r_tag_cnt + c_tag_one;
            end
            unique case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - c_cred_one;
                2'b01:   r_credits <= r_credits + c_cred_one;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Stage i holds the op whose operands reached the ALU i cycles ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i <= LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_tag[0] <= r_tag_cnt;
        for (int i = 1; i <= LATENCY; i++) begin
            r_tag[i] <= r_tag[i-1];
        end
    end

    alu_rsp_fifo #(
        .DEPTH (DEPTH),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign alu_opsel = reset ? 1'b0 : r_opsel;
    assign alu_in0   = reset ? '0   : r_in0;
    assign alu_in1   = reset ? '0   : r_in1;
    assign rsp_data  = reset ? '0   : w_head.data;
    assign rsp_tag   = reset ? '0   : w_head.tag;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_credits <= c_cred_max)
                else $error("alu_issuer: credits above DEPTH");
            assert (!(w_push && w_full && !w_pop))
                else $error("alu_issuer: push into full buffer");
            assert (!(w_pop && w_empty))
                else $error("alu_issuer: pop from empty buffer");
            assert (int'(r_credits) + $countones(r_vld) + int'(w_count) == DEPTH)
                else $error("alu_issuer: credit accounting broken");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issuer.sv
// ============================================================================
// Module   : tb_alu_issuer
// Brief    : Self-checking bench for alu_issuer with a 2-cycle ALU model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issuer;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int DEP = 4;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_opsel;
    logic [W-1:0]  cmd_in0;
    logic [W-1:0]  cmd_in1;
    logic          alu_opsel;
    logic [W-1:0]  alu_in0;
    logic [W-1:0]  alu_in1;
    logic [W-1:0]  alu_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic [TW-1:0] rsp_tag;

    always #5 clk = ~clk;

    alu_issuer #(
        .WIDTH   (W),
        .LATENCY (LAT),
        .DEPTH   (DEP),
        .TAG_W   (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opsel (cmd_opsel),
        .cmd_in0   (cmd_in0),
        .cmd_in1   (cmd_in1),
        .alu_opsel (alu_opsel),
        .alu_in0   (alu_in0),
        .alu_in1   (alu_in1),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag)
    );

    function automatic logic [W-1:0] alu_f(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        return (op == OP_ADD) ? a + b : a * b;
    endfunction

    // Fixed-latency ALU: out reflects the operands LAT cycles after they appear.
    logic [W-1:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_f(alu_opsel, alu_in0, alu_in1);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_out = alu_pipe[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t          sb_q[$];
    logic [TW-1:0] sb_tag;
    logic [TW-1:0] popped_tags[$];
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data;
    logic [TW-1:0] prev_tag;

    // Scoreboard: handshakes seen here complete at the following rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            sb_q.delete();
            sb_tag     = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(rsp_valid), 64'd1);
                chk("hold_data", 64'(rsp_data), 64'(prev_data));
                chk("hold_tag", 64'(rsp_tag), 64'(prev_tag));
            end
            if (!rsp_valid) chk("idle_data_zero", 64'(rsp_data), 64'd0);
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 64'(rsp_data), 64'(e.data));
                    chk("sb_tag", 64'(rsp_tag), 64'(e.tag));
                end
                popped_tags.push_back(rsp_tag);
            end
            if (cmd_valid && cmd_ready) begin
                sb_q.push_back('{data: alu_f(cmd_opsel, cmd_in0, cmd_in1), tag: sb_tag});
                sb_tag = sb_tag + 1'b1;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            prev_tag   = rsp_tag;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
        logic ok;
        ok        = 1'b0;
        waited    = 0;
        cmd_opsel = op;
        cmd_in0   = a;
        cmd_in1   = b;
        cmd_valid = 1'b1;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            else waited++;
            tick();
        end
        cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic          op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  exp;
        logic [TW-1:0] tag;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #300000;
        bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : test
        int w, n, acc, idx, seen;
        logic got;

        tbl[0] = '{OP_ADD, 32'd2,          32'd4,       32'd6,          4'd0};
        tbl[1] = '{OP_MUL, 32'd2,          32'd4,       32'd8,          4'd1};
        tbl[2] = '{OP_MUL, 32'hFFFF_FFFF,  32'd2,       32'hFFFF_FFFE,  4'd2};
        tbl[3] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,       32'd0,          4'd3};
        tbl[4] = '{OP_MUL, 32'h0001_0000,  32'h0001_0000, 32'd0,        4'd4};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_opsel = 1'b0;
        cmd_in0   = '0;
        cmd_in1   = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_alu_opsel", 64'(alu_opsel), 64'd0);
        chk("rst_alu_in0", 64'(alu_in0), 64'd0);
        chk("rst_alu_in1", 64'(alu_in1), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);
        tick();

        // Isolated ops: latency, one-cycle operand window and result per vector.
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_opsel = tbl[i].op;
            cmd_in0   = tbl[i].a;
            cmd_in1   = tbl[i].b;
            cmd_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 64'(cmd_ready), 64'd1);
            tick();
            cmd_valid = 1'b0;
            n   = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                n++;
                if (n == 1) begin
                    chk($sformatf("tbl%0d_alu_opsel", i), 64'(alu_opsel), 64'(tbl[i].op));
                    chk($sformatf("tbl%0d_alu_in0", i), 64'(alu_in0), 64'(tbl[i].a));
                    chk($sformatf("tbl%0d_alu_in1", i), 64'(alu_in1), 64'(tbl[i].b));
                end
                if (n == 2) begin
                    chk($sformatf("tbl%0d_alu_in0_idle", i), 64'(alu_in0), 64'd0);
                    chk($sformatf("tbl%0d_alu_in1_idle", i), 64'(alu_in1), 64'd0);
                end
                if (rsp_valid) begin
                    got = 1'b1;
                    chk($sformatf("tbl%0d_latency", i), 64'(n), 64'd4);
                    chk($sformatf("tbl%0d_data", i), 64'(rsp_data), 64'(tbl[i].exp));
                    chk($sformatf("tbl%0d_tag", i), 64'(rsp_tag), 64'(tbl[i].tag));
                end
            end
            if (!got) chk($sformatf("tbl%0d_rsp_timeout", i), 64'd0, 64'd1);
            tick();
        end

        // Back-to-back adds: no stall on issue, results on consecutive cycles.
        do_reset(2);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(OP_ADD, W'(i + 1), W'(i + 1), w);
            chk($sformatf("b2b_wait%0d", i), 64'(w), 64'd0);
        end
        got = 1'b0;
        for (int m = 0; m < 20 && !got; m++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        if (!got) chk("b2b_rsp_timeout", 64'd0, 64'd1);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge clk);
            chk($sformatf("b2b_valid%0d", j), 64'(rsp_valid), 64'd1);
            chk($sformatf("b2b_data%0d", j), 64'(rsp_data), 64'(2 * (j + 1)));
            chk($sformatf("b2b_tag%0d", j), 64'(rsp_tag), 64'(j));
        end
        @(negedge clk);
        chk("b2b_empty", 64'(rsp_valid), 64'd0);
        tick();

        // Backpressure: credits cap acceptance at DEPTH, released one per pop.
        do_reset(2);
        rsp_ready = 1'b0;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            cmd_opsel = OP_ADD;
            cmd_in0   = W'(10 + idx);
            cmd_in1   = W'(idx);
            cmd_valid = (idx < 6);
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                acc++;
                idx++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        chk("bp_ready_full", 64'(cmd_ready), 64'd0);
        chk("bp_valid_full", 64'(rsp_valid), 64'd1);
        tick();
        rsp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("bp_ready%0d", j), 64'(cmd_ready), (j == 0) ? 64'd0 : 64'd1);
            chk($sformatf("bp_valid%0d", j), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp_data%0d", j), 64'(rsp_data), 64'(10 + 2 * j));
            chk($sformatf("bp_tag%0d", j), 64'(rsp_tag), 64'(j));
        end
        @(negedge clk);
        chk("bp_drained", 64'(rsp_valid), 64'd0);
        tick();

        // Reset with two ops in flight: both discarded, state fully restored.
        do_reset(2);
        rsp_ready = 1'b1;
        send(OP_ADD, 32'd7, 32'd1, w);
        send(OP_MUL, 32'd3, 32'd5, w);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_alu_in0", 64'(alu_in0), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", 64'(seen), 64'd0);
        tick();
        rsp_ready = 1'b0;
        acc       = 0;
        cmd_opsel = OP_ADD;
        cmd_in0   = 32'd5;
        cmd_in1   = 32'd5;
        cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cmd_ready) acc++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("mid_rst_credits", 64'(acc), 64'(DEP));
        @(negedge clk);
        chk("mid_rst_first_tag", 64'(rsp_tag), 64'd0);
        chk("mid_rst_first_data", 64'(rsp_data), 64'd10);
        tick();
        rsp_ready = 1'b1;
        repeat (8) tick();

        // Tag wrap: 17 ops give tags 0..15 then 0.
        do_reset(2);
        rsp_ready = 1'b1;
        popped_tags.delete();
        for (int i = 0; i < 17; i++) send(OP_MUL, W'(i), 32'd3, w);
        n = 0;
        while (popped_tags.size() < 17 && n < 100) begin
            tick();
            n++;
        end
        chk("wrap_count", 64'(popped_tags.size()), 64'd17);
        for (int i = 0; i < 17; i++) begin
            if (i < popped_tags.size())
                chk($sformatf("wrap_tag%0d", i), 64'(popped_tags[i]), (i < 16) ? 64'(i) : 64'd0);
        end

        repeat (4) tick();
        @(negedge clk);
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
